// File: rtl/i2c_req_arbiter_if.sv
// Master-side port of the I2C request arbiter:
// newd/op/addr/din out, dout/busy/ack_err/done back.
interface i2c_req_arbiter_if;
  logic       m_newd;
  logic       m_op;
  logic [6:0] m_addr;
  logic [7:0] m_din;
  logic [7:0] m_dout;
  logic       m_busy;
  logic       m_ack_err;
  logic       m_done;

  modport master (
    output m_newd, m_op, m_addr, m_din,
    input  m_dout, m_busy, m_ack_err, m_done
  );

  modport slave (
    input  m_newd, m_op, m_addr, m_din,
    output m_dout, m_busy, m_ack_err, m_done
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master among N_REQ clients.
// Define I2C_ARB_TIMEOUT_EN to add a WAIT-state watchdog.
module i2c_req_arbiter #(
  parameter int N_REQ          = 4,
  parameter int NEWD_HOLD      = 5,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_op,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_din,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               rsp_err,
  output logic               arb_busy,
  i2c_req_arbiter_if.master  m
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(NEWD_HOLD + 1);

  if (N_REQ < 2 || N_REQ > 8 || NEWD_HOLD < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("i2c_req_arbiter: illegal parameter");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic             newd_q, newd_d;
  logic             op_q, op_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       din_q, din_d;
  logic             done_q;
  logic             done_edge;
  logic             found;
  logic [PW-1:0]    win_idx;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]    wdog_q, wdog_d;
`endif

  assign done_edge = m.m_done & ~done_q;

  // First requester at or after rr_ptr, wrapping
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[(int'(rr_ptr_q) + i) % N_REQ]) begin
        found   = 1'b1;
        win_idx = PW'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    newd_d      = newd_q;
    op_d        = op_q;
    addr_d      = addr_q;
    din_d       = din_q;
`ifdef I2C_ARB_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found && !m.m_busy) begin
          state_d  = ISSUE;
          gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          rr_ptr_d = PW'((int'(win_idx) + 1) % N_REQ);
          hold_d   = '0;
          op_d     = req_op[win_idx];
          addr_d   = req_addr[int'(win_idx)*7 +: 7];
          din_d    = req_din[int'(win_idx)*8 +: 8];
        end
      end
      ISSUE: begin
        if (hold_q == HW'(NEWD_HOLD)) begin
          newd_d  = 1'b0;
          state_d = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end else begin
          newd_d = 1'b1;
          hold_d = hold_q + HW'(1);
        end
      end
      WAIT: begin
        if (done_edge) begin
          state_d     = RESP;
          rsp_valid_d = gnt_q;
          rsp_data_d  = op_q ? m.m_dout : 8'h00;
          rsp_err_d   = m.m_ack_err;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          rsp_valid_d = gnt_q;
          rsp_data_d  = 8'h00;
          rsp_err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
`endif
      end
      RESP: begin
        state_d    = IDLE;
        gnt_d      = '0;
        rsp_data_d = 8'h00;
        rsp_err_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      newd_q      <= 1'b0;
      op_q        <= 1'b0;
      addr_q      <= 7'h00;
      din_q       <= 8'h00;
      done_q      <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      newd_q      <= newd_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      done_q      <= m.m_done;
`ifdef I2C_ARB_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign arb_busy  = busy_q;
  assign m.m_newd  = newd_q;
  assign m.m_op    = op_q;
  assign m.m_addr  = addr_q;
  assign m.m_din   = din_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: vector table, corner sequences,
// and random traffic against a behavioural round-robin model.
module tb_i2c_req_arbiter;

  localparam int N  = 4;
  localparam int NH = 5;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, req_op;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_din;
  logic [N-1:0]  gnt, rsp_valid;
  logic [7:0]    rsp_data;
  logic          rsp_err, arb_busy;

  i2c_req_arbiter_if mif ();

  i2c_req_arbiter #(
    .N_REQ(N), .NEWD_HOLD(NH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_op(req_op),
    .req_addr(req_addr), .req_din(req_din),
    .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .arb_busy(arb_busy), .m(mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit model_en = 1'b1;

  logic [7:0] slave_mem [128];
  logic [7:0] ref_mem [128];

  function automatic bit is_nack(input logic [6:0] a);
    return a[6:3] == 4'hF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  // Behavioural I2C master + memory slave; NACKs addresses 0x78..0x7F
  initial begin : slave
    bit         s_busy;
    int         s_lat;
    logic       s_op;
    logic [6:0] s_addr;
    logic [7:0] s_din;
    s_busy = 0;
    mif.m_busy = 0; mif.m_done = 0;
    mif.m_ack_err = 0; mif.m_dout = 0;
    forever begin
      @(posedge clk); #1;
      if (!model_en) begin s_busy = 0; continue; end
      if (rst) begin
        s_busy = 0; mif.m_busy = 0; mif.m_done = 0;
        continue;
      end
      mif.m_done = 0;
      if (s_busy) begin
        if (s_lat == 0) begin
          s_busy = 0; mif.m_busy = 0; mif.m_done = 1;
          if (is_nack(s_addr)) begin
            mif.m_ack_err = 1; mif.m_dout = 0;
          end else begin
            mif.m_ack_err = 0;
            if (s_op) mif.m_dout = slave_mem[s_addr];
            else begin
              slave_mem[s_addr] = s_din; mif.m_dout = 0;
            end
          end
        end else s_lat--;
      end else if (mif.m_newd) begin
        s_busy = 1; mif.m_busy = 1;
        s_op = mif.m_op; s_addr = mif.m_addr; s_din = mif.m_din;
        s_lat = NH + int'($urandom_range(0, 6));
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) @(negedge clk);
    rst = 0;
  endtask

  task automatic manual_bus();
    model_en = 0;
    mif.m_busy = 0; mif.m_done = 0;
    mif.m_ack_err = 0; mif.m_dout = 0;
  endtask

  // Returns just after the edge where m_newd falls (WAIT entry)
  task automatic wait_wait_entry(output bit ok);
    bit hi;
    ok = 0; hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mif.m_newd) hi = 1;
      else if (hi) begin ok = 1; break; end
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    logic         op;
    logic [6:0]   addr;
    logic [7:0]   din;
    logic [N-1:0] exp_gnt;
    logic [7:0]   exp_data;
    logic         exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input int k);
    int  ncnt;
    bit  g, r;
    ncnt = 0; g = 0; r = 0;
    req = v.req; req_op = {N{v.op}};
    req_addr = {N{v.addr}}; req_din = {N{v.din}};
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!g && gnt != 0) begin
        g = 1;
        chk($sformatf("vec%0d gnt", k), gnt, v.exp_gnt);
        chk($sformatf("vec%0d newd_lat", k), mif.m_newd, 0);
        req_op = ~req_op; req_addr = ~req_addr;
        req_din = ~req_din;
      end
      if (mif.m_newd) begin
        ncnt++;
        if (ncnt == 1)
          chk($sformatf("vec%0d bus", k),
              {mif.m_op, mif.m_addr, mif.m_din},
              {v.op, v.addr, v.din});
      end
      if (rsp_valid != 0) begin
        chk($sformatf("vec%0d rsp_valid", k), rsp_valid, v.exp_gnt);
        chk($sformatf("vec%0d rsp_data", k), rsp_data, v.exp_data);
        chk($sformatf("vec%0d rsp_err", k), rsp_err, v.exp_err);
        chk($sformatf("vec%0d newd_len", k), ncnt, NH);
        req = 0; r = 1;
        break;
      end
    end
    if (!r) begin
      bound_fail($sformatf("vec%0d response", k));
      req = 0;
    end
    @(negedge clk);
  endtask

  vec_t vt [8];

  initial begin
    int         order [5];
    int         ng, cnt, want, cur, served;
    bit         ok, any;
    logic [N-1:0] gprev;
    bit         pend [N];
    int         waitc [N];
    logic       op_a [N];
    logic [6:0] addr_a [N];
    logic [7:0] din_a [N];
    logic       cur_op;
    logic [6:0] cur_addr;
    logic [7:0] cur_din;
    int         ncnt;
    bit         drain;

    for (int i = 0; i < 128; i++) begin
      slave_mem[i] = 0; ref_mem[i] = 0;
    end
    req = 0; req_op = 0; req_addr = 0; req_din = 0;

    // Reset state and idle hold
    rst = 1;
    repeat (5) @(negedge clk);
    chk("rst gnt", gnt, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst m_newd", mif.m_newd, 0);
    chk("rst arb_busy", arb_busy, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("idle arb_busy", arb_busy, 0);
    chk("idle gnt", gnt, 0);

    vt[0] = '{4'b0010, 1'b0, 7'h03, 8'h05, 4'b0010, 8'h00, 1'b0};
    vt[1] = '{4'b0100, 1'b1, 7'h03, 8'h00, 4'b0100, 8'h05, 1'b0};
    vt[2] = '{4'b0001, 1'b0, 7'h7A, 8'h11, 4'b0001, 8'h00, 1'b1};
    vt[3] = '{4'b1000, 1'b1, 7'h03, 8'h00, 4'b1000, 8'h05, 1'b0};
    vt[4] = '{4'b1010, 1'b0, 7'h10, 8'hA5, 4'b0010, 8'h00, 1'b0};
    vt[5] = '{4'b1010, 1'b1, 7'h10, 8'h00, 4'b1000, 8'hA5, 1'b0};
    vt[6] = '{4'b0001, 1'b1, 7'h7A, 8'h00, 4'b0001, 8'h00, 1'b1};
    vt[7] = '{4'b0101, 1'b1, 7'h10, 8'h00, 4'b0100, 8'hA5, 1'b0};
    for (int k = 0; k < 8; k++) run_vec(vt[k], k);

    // All requesting from reset: strict rotation, one-hot grants
    req = 4'b1111; req_op = 0;
    req_addr = {N{7'h20}}; req_din = {N{8'h5A}};
    do_reset(3);
    ng = 0; gprev = 0;
    for (int c = 0; c < 500 && ng < 5; c++) begin
      @(negedge clk);
      chk("rr onehot", $onehot0(gnt), 1);
      if (gnt != 0 && gprev == 0) begin
        order[ng] = onehot_idx(gnt); ng++;
      end
      gprev = gnt;
    end
    if (ng < 5) bound_fail("rr grants");
    else for (int i = 0; i < 5; i++)
      chk($sformatf("rr order%0d", i), order[i], i % N);
    req = 0;
    for (int c = 0; c < 100 && arb_busy; c++) @(negedge clk);

    // Reset while waiting for done
    do_reset(2);
    manual_bus();
    req = 4'b0010;
    wait_wait_entry(ok);
    if (!ok) bound_fail("midwait entry");
    rst = 1;
    @(negedge clk);
    chk("midwait gnt", gnt, 0);
    chk("midwait busy", arb_busy, 0);
    chk("midwait bus",
        {rsp_valid, rsp_data, rsp_err, mif.m_newd,
         mif.m_op, mif.m_addr, mif.m_din}, 0);
    rst = 0; req = 4'b1111;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt != 0) begin ok = 1; break; end
    end
    if (!ok) bound_fail("midwait regrant");
    else chk("midwait rr_ptr", gnt, 4'b0001);
    req = 0;
    do_reset(2);

    // done already high on WAIT entry is not an edge
    req = 4'b0100; req_op = 4'b0100;
    mif.m_dout = 8'h3C;
    for (int c = 0; c < 10 && gnt == 0; c++) @(negedge clk);
    mif.m_done = 1;
    wait_wait_entry(ok);
    if (!ok) bound_fail("dlevel entry");
    any = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid != 0) any = 1;
    end
    chk("dlevel no_rsp", any, 0);
    mif.m_done = 0;
    @(negedge clk);
    mif.m_done = 1;
    ok = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin ok = 1; break; end
    end
    if (!ok) bound_fail("dlevel rsp");
    else begin
      chk("dlevel rsp_valid", rsp_valid, 4'b0100);
      chk("dlevel rsp_data", rsp_data, 8'h3C);
    end
    mif.m_done = 0; req = 0; req_op = 0;
    @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog with done stuck low
    do_reset(2);
    req = 4'b0001; req_op = 4'b0001;
    mif.m_dout = 8'hEE;
    wait_wait_entry(ok);
    if (!ok) bound_fail("tmo entry");
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cnt++;
      if (rsp_valid != 0) break;
    end
    chk("tmo cycles", cnt, TO);
    chk("tmo rsp_err", rsp_err, 1);
    chk("tmo rsp_data", rsp_data, 0);
    req = 0; req_op = 0;
`endif

    // Random traffic against the reference model
    manual_bus();
    model_en = 1;
    do_reset(3);
    for (int i = 0; i < 128; i++) begin
      slave_mem[i] = 0; ref_mem[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; waitc[i] = 0;
      op_a[i] = 0; addr_a[i] = 0; din_a[i] = 0;
    end
    want = 0; cur = -1; gprev = 0; ncnt = 0;
    served = 0; drain = 0;
    cur_op = 0; cur_addr = 0; cur_din = 0;
    for (int c = 0; c < 6000; c++) begin
      int rr_next;
      @(negedge clk);
      if (c == 4000) drain = 1;
      if (gnt != 0 && gprev == 0) begin
        rr_next = -1;
        for (int i = 0; i < N; i++)
          if (rr_next < 0 && req[(want + i) % N])
            rr_next = (want + i) % N;
        chk("rand gnt", gnt,
            rr_next < 0 ? 0 : (1 << rr_next));
        chk("rand newd_lat", mif.m_newd, 0);
        if (rr_next >= 0) begin
          chk("rand starve", waitc[rr_next] <= N - 1, 1);
          for (int i = 0; i < N; i++)
            if (req[i] && i != rr_next) waitc[i]++;
          waitc[rr_next] = 0;
          cur = rr_next; want = (rr_next + 1) % N;
          cur_op = op_a[cur]; cur_addr = addr_a[cur];
          cur_din = din_a[cur];
        end
        ncnt = 0;
      end
      gprev = gnt;
      chk("rand busy", arb_busy, |gnt);
      if (cur >= 0) begin
        chk("rand stable", {mif.m_op, mif.m_addr, mif.m_din},
            {cur_op, cur_addr, cur_din});
        if (mif.m_newd) ncnt++;
      end
      if (rsp_valid != 0) begin
        chk("rand rsp_valid", rsp_valid,
            cur >= 0 ? (1 << cur) : 0);
        if (cur >= 0) begin
          chk("rand rsp_err", rsp_err, is_nack(cur_addr));
          chk("rand rsp_data", rsp_data,
              (cur_op && !is_nack(cur_addr)) ?
              ref_mem[cur_addr] : 8'h00);
          chk("rand newd_len", ncnt, NH);
          if (!cur_op && !is_nack(cur_addr))
            ref_mem[cur_addr] = cur_din;
          pend[cur] = 0; waitc[cur] = 0;
          served++;
        end
        cur = -1;
      end
      if (drain) begin
        ok = 1;
        for (int i = 0; i < N; i++) if (pend[i]) ok = 0;
        if (ok && cur < 0 && !arb_busy) break;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && !drain && $urandom_range(0, 3) == 0) begin
          pend[i] = 1; waitc[i] = 0;
        end else if (pend[i] && i != cur &&
                     $urandom_range(0, 63) == 0) begin
          pend[i] = 0; waitc[i] = 0;
        end
        if ($urandom_range(0, 2) == 0) begin
          op_a[i]   = 1'($urandom_range(0, 1));
          addr_a[i] = 7'($urandom_range(0, 7));
          if ($urandom_range(0, 5) == 0) addr_a[i][6:3] = 4'hF;
          din_a[i]  = 8'($urandom);
        end
        req[i]            = pend[i];
        req_op[i]         = op_a[i];
        req_addr[i*7 +: 7] = addr_a[i];
        req_din[i*8 +: 8]  = din_a[i];
      end
    end
    ok = 1;
    for (int i = 0; i < N; i++) if (pend[i]) ok = 0;
    if (!ok || cur >= 0) bound_fail("rand drain");
    chk("rand served_any", served > 50, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
